shared_unit_arbiter: RTL and testbench
======================================

# shared_unit_arbiter

Round-robin arbiter that shares one combinational logic unit (e.g. the 3-input OR/ALU slice) among three requesters in the CPU datapath. It issues a registered one-hot grant, holds it while the owner keeps requesting, and inserts one idle cycle between owners so the shared operand bus is never driven by two sources. An optional hold-time limit, selected at compile time, stops any single requester from monopolising the unit.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per ownership. Legal range 1..255. Used only when the timeout feature is compiled in.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous reset, active-high.
- `req`, input, 3: request from requester i; level-sensitive.
- `grant`, output, 3: one-hot or zero grant; registered.
- `busy`, output, 1: OR of `grant` bits; registered.
- `owner`, output, 2: index of the granted requester; 2'd3 when there is no grant.
- `expired`, output, 1: one-cycle pulse when a grant is force-released by the timeout.

## Operation
- State machine with states IDLE, GRANT and GAP.
- Pointer `ptr` (0..2) names the highest-priority requester. The search order is `ptr`, `ptr+1`, `ptr+2` (mod 3).
- **IDLE:**
  - `grant` is 0.
  - If any `req` bit is high, grant the first set bit in search order and go to GRANT.
- **GRANT:**
  - `grant[i]` is held.
  - If `req[i]` is sampled low, go to GAP and set `ptr=(i+1)%3`.
  - With the timeout feature, the same transition also happens when the hold count reaches `MAX_HOLD`; in that case `expired` is pulsed.
- **GAP:**
  - `grant` is 0 for exactly one cycle.
  - At the end of GAP, arbitrate exactly as IDLE does: go to GRANT if any request is pending, otherwise go to IDLE.
- A requester whose grant was force-released but keeps `req` high is an ordinary requester. Because `ptr` has advanced, the other requesters get priority first. If it is the only requester, it is re-granted after the GAP cycle.
- Changes to `req` for non-owners while in GRANT have no effect until the next arbitration.
- Output values at a glance:
  - `owner` is the index of the granted requester, or 3 when there is no grant.
  - `busy` equals `|grant`.
  - `grant` is never multi-hot.

## Timing
- **Reset:** at a rising edge with `reset=1`, the block takes these values regardless of state:
  - `grant=0`, `busy=0`, `owner=3`, `expired=0`
  - state IDLE, `ptr=0`, hold count 0
  - Reset mid-grant drops the grant at that same edge.
- **Grant latency:** if `req` is sampled high in IDLE at edge N, `grant` is high after edge N. This is one cycle from request to grant.
- **Release:** if `req[i]` is sampled low at edge N, `grant` goes low after edge N. The earliest next grant is after edge N+1.
- **Handoff:** back-to-back owners are always separated by exactly one zero-grant cycle.
- **Hold counter** (8 bits, only with the timeout feature):
  - Loads 1 on the edge that asserts a grant.
  - Increments on each edge that stays in GRANT.
  - At the edge where count==`MAX_HOLD` and `req[i]` is still high, the grant drops. The grant is therefore high for exactly `MAX_HOLD` cycles.
  - `expired` is high during the following GAP cycle only.
- **Simultaneous events:** if `req[i]` falls on the same edge that the count reaches `MAX_HOLD`, treat it as a normal release with `expired=0`.

## Configuration
- Macro: `SHARED_ARB_TIMEOUT_EN`.
- **Defined:** the hold counter and `expired` logic are built, and `MAX_HOLD` is enforced as above.
- **Undefined:**
  - No counter is built.
  - A grant is held for as long as the owner's `req` stays high.
  - `expired` is tied to 0.
  - `MAX_HOLD` is ignored.

## Test plan
- **Single request:** reset, then `req=3'b010` from cycle 2. Required: `grant=3'b010`, `owner=1`, `busy=1` from cycle 3 onward. Drop `req` at cycle 6: `grant=0`, `owner=3` from cycle 7.
- **Fair rotation:** all three `req` high, each owner drops `req` for one cycle after holding 3 cycles. Required: grant order 0, 1, 2, 0, with exactly one `grant=0` cycle between owners, and never multi-hot.
- **Pending handoff:** `req[0]` is granted while `req[2]` is raised. Drop `req[0]` at edge N. Required: GAP after edge N, then `grant=3'b100` after edge N+1.
- **Timeout** (macro defined, `MAX_HOLD=4`): hold `req[1]=1` alone. Required: `grant[1]` high exactly 4 cycles, `expired=1` for one cycle with `grant=0`, then `grant[1]` re-asserted. Repeat with `req[0]` also high: the second grant goes to requester 2's successor in order, i.e. requester 0 (`ptr=2`, with 2 idle).
- **Reset mid-operation:** assert `reset` for one edge during GRANT of requester 2. Required: all outputs at reset values after that edge. With all `req` high afterwards, the first grant is `3'b001`.
- **No timeout** (macro undefined): hold `req[0]` for 100 cycles. Required: `grant[0]` continuously high for 100 cycles and `expired` never asserted.

Source files
------------

// File: rtl/shared_unit_arbiter.sv
// shared_unit_arbiter
// Round-robin arbiter sharing one combinational unit among three requesters.
// A registered one-hot grant is held while its owner keeps requesting, and
// one zero-grant cycle (GAP) always separates two owners so the shared
// operand bus never has two drivers.
//
// Optional feature: define SHARED_ARB_TIMEOUT_EN to build an 8-bit hold
// counter that force-releases a grant after MAX_HOLD cycles and pulses
// `expired` during the following GAP cycle. Without the macro there is no
// counter, `expired` stays 0 and MAX_HOLD has no effect.
//
// Ports:
//   clk      - clock, rising-edge
//   reset    - synchronous, active-high
//   req[2:0] - level-sensitive requests
//   grant    - registered one-hot (or zero) grant
//   busy     - registered OR of grant
//   owner    - index of the granted requester, 3 when none
//   expired  - one-cycle pulse after a timeout release
//
// Handshake: req[i] is a level; once grant[i] is seen, requester i owns the
// unit for every cycle grant[i] stays high, and releases it by dropping
// req[i] (sampled at the next rising edge).

module shared_unit_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic       busy,
    output logic [1:0] owner,
    output logic       expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state;
    logic [1:0] ptr;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Candidate order: ptr, ptr+1, ptr+2 (mod 3).
    logic [1:0] cand0, cand1, cand2;
    logic [1:0] pick_idx;
    logic       pick_valid;

    always_comb begin
        cand0 = ptr;
        cand1 = inc3(ptr);
        cand2 = inc3(cand1);
        pick_valid = |req;
        if (req[cand0])
            pick_idx = cand0;
        else if (req[cand1])
            pick_idx = cand1;
        else
            pick_idx = cand2;
    end

    // The owner still requests iff its grant bit meets its req bit.
    logic owner_req;
    assign owner_req = |(grant & req);

    logic timeout_hit;

`ifdef SHARED_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign timeout_hit = (hold_cnt == HOLD_LIMIT);

    always_ff @(posedge clk) begin
        if (reset)
            hold_cnt <= 8'd0;
        else if (state != GRANT)
            hold_cnt <= (pick_valid) ? 8'd1 : 8'd0;
        else if (owner_req && !timeout_hit)
            hold_cnt <= hold_cnt + 8'd1;
        else
            hold_cnt <= 8'd0;
    end
`else
    assign timeout_hit = 1'b0;

    // MAX_HOLD has no effect in this build.
    logic unused_hold_limit;
    assign unused_hold_limit = ^HOLD_LIMIT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            grant   <= 3'b000;
            busy    <= 1'b0;
            owner   <= 2'd3;
            expired <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    expired <= 1'b0;
                    if (pick_valid) begin
                        state <= GRANT;
                        grant <= 3'b001 << pick_idx;
                        busy  <= 1'b1;
                        owner <= pick_idx;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // A release by the owner on the same edge as the limit
                    // counts as a normal release, so expired needs owner_req.
                    if (!owner_req || timeout_hit) begin
                        state   <= GAP;
                        grant   <= 3'b000;
                        busy    <= 1'b0;
                        owner   <= 2'd3;
                        ptr     <= inc3(owner);
                        expired <= owner_req & timeout_hit;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant   <= 3'b000;
                    busy    <= 1'b0;
                    owner   <= 2'd3;
                    expired <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Testbench for shared_unit_arbiter: directed scenarios followed by random
// request patterns, checked cycle by cycle against a reference model.

module tb_shared_unit_arbiter;

    localparam int TB_MAX_HOLD = 4;
`ifdef SHARED_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] grant;
    logic       busy;
    logic [1:0] owner;
    logic       expired;

    always #5 clk = ~clk;

    shared_unit_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .busy    (busy),
        .owner   (owner),
        .expired (expired)
    );

    // ---------------- reference model ----------------
    // Expected {grant, busy, owner, expired} after each rising edge.
    logic [6:0] exp_q[$];
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int total   = 0;
    int bad     = 0;
    int cyc     = 0;

    always @(posedge clk) begin
        bit         m_exp;
        logic [2:0] g;
        logic [1:0] o;
        m_exp = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner] || (TO_EN && m_held == TB_MAX_HOLD)) begin
                m_exp   = req[m_owner];
                m_ptr   = (m_owner + 1) % 3;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 3]) begin
                    m_owner = (m_ptr + k) % 3;
                    m_held  = 1;
                end
            end
        end
        g = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
        o = (m_owner < 0) ? 2'd3 : 2'(m_owner);
        exp_q.push_back({g, |g, o, m_exp});
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [6:0] e;
        cyc++;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL cyc=%0d no_expected got grant=%b", cyc, grant);
        end else begin
            e = exp_q.pop_front();
            if ({grant, busy, owner, expired} !== e) begin
                bad++;
                $display("FAIL cyc=%0d outputs got g=%b b=%b o=%0d x=%b want g=%b b=%b o=%0d x=%b",
                         cyc, grant, busy, owner, expired, e[6:4], e[3], e[2:1], e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] r, input int n);
        req = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // single request, then release
        drive(3'b010, 4);
        drive(3'b000, 3);

        // fair rotation: each owner holds 3 cycles then drops for one
        rst_pulse();
        drive(3'b111, 3);
        drive(3'b110, 1);
        drive(3'b111, 3);
        drive(3'b101, 1);
        drive(3'b111, 3);
        drive(3'b011, 1);
        drive(3'b111, 3);
        drive(3'b000, 2);

        // pending handoff 0 -> 2
        rst_pulse();
        drive(3'b001, 2);
        drive(3'b101, 2);
        drive(3'b100, 3);
        drive(3'b000, 2);

        // hold timeout: alone, then with requester 0 competing
        rst_pulse();
        drive(3'b010, 12);
        drive(3'b000, 2);
        drive(3'b010, 3);
        drive(3'b011, 12);
        drive(3'b000, 2);

        // reset during requester 2's grant, then all requesting
        drive(3'b100, 3);
        req = 3'b111;
        rst_pulse();
        drive(3'b111, 4);
        drive(3'b000, 2);

        // long hold by requester 0
        drive(3'b001, 100);
        drive(3'b000, 2);

        // random request patterns with occasional resets
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0)
                rst_pulse();
            drive(3'($urandom_range(0, 7)), $urandom_range(1, 8));
        end
        drive(3'b000, 3);

        repeat (2) @(posedge clk);
        #7;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
